// File: rtl/reg_pkg.sv
// Shared scoreboard definitions: default geometry, context encoding and the flat-bus slice helper.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package reg_pkg;

   localparam int DEF_NUM_PREG  = 64;
   localparam int DEF_WORD_W    = 32;
   localparam int DEF_CTX_W     = 4;
   localparam int DEF_NUM_ISSUE = 2;
   localparam int DEF_NUM_WB    = 2;
   localparam int AW            = $clog2(DEF_NUM_PREG);

   // A pend entry of all zeros means "no writer in flight" for that register.
   // Wide enough for any practical CTX_W; users truncate to their own width.
   localparam logic [31:0] CONTEXT_ZERO = '0;

   // Issue and writeback buses are flat vectors. Field f of slot or port i
   // lives at [fidx(i, W) +: W], where W is the width of that field.
   function automatic int fidx(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/scb_regfile.sv
// Physical register file: NUM_RD combinational read ports and NUM_WR write ports; register 0 reads as zero.
// Latency: reads are combinational; writes land at the next posedge, with the highest write port winning.
// Backpressure: none; every asserted write enable is taken.
module scb_regfile
   import reg_pkg::*;
#(
   parameter int NUM_PREG = DEF_NUM_PREG,
   parameter int WORD_W   = DEF_WORD_W,
   parameter int NUM_RD   = 5,
   parameter int NUM_WR   = DEF_NUM_WB,
   localparam int ADDR_W  = $clog2(NUM_PREG)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*WORD_W-1:0]   rd_data,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*WORD_W-1:0]   wr_data
);

   logic [WORD_W-1:0] regs_q [NUM_PREG];
   logic [WORD_W-1:0] regs_d [NUM_PREG];

   // Next-state: apply write ports in ascending order so the highest port wins a collision.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && (wr_addr[fidx(j, ADDR_W) +: ADDR_W] != '0)) begin
            regs_d[wr_addr[fidx(j, ADDR_W) +: ADDR_W]] = wr_data[fidx(j, WORD_W) +: WORD_W];
         end
      end
      regs_d[0] = '0;
   end

   // Register state, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < NUM_PREG; p++) begin
            regs_q[p] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational read ports with register-0 masking.
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         if (rd_addr[fidx(r, ADDR_W) +: ADDR_W] != '0) begin
            rd_data[fidx(r, WORD_W) +: WORD_W] = regs_q[rd_addr[fidx(r, ADDR_W) +: ADDR_W]];
         end
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: register file plus per-register pending-context table, gating in-order multi-issue on RAW/WAW.
// Latency: issue decisions and operand reads are combinational; table and register updates land at the next posedge.
// Backpressure: iss_ready stalls the first hazarded slot and all later ones; writebacks are never stalled.
// Optional macro SCB_FORWARD_EN: effective writebacks clear hazards and forward data to issue in the same cycle.
module reg_scoreboard
   import reg_pkg::*;
#(
   parameter int NUM_PREG  = DEF_NUM_PREG,
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CTX_W     = DEF_CTX_W,
   parameter int NUM_ISSUE = DEF_NUM_ISSUE,
   parameter int NUM_WB    = DEF_NUM_WB,
   parameter int LR_ADDR   = 1,
   localparam int ADDR_W   = $clog2(NUM_PREG)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_ISSUE-1:0]          iss_valid,
   input  logic [NUM_ISSUE*ADDR_W-1:0]   iss_rs1,
   input  logic [NUM_ISSUE*ADDR_W-1:0]   iss_rs2,
   input  logic [NUM_ISSUE*ADDR_W-1:0]   iss_rd,
   input  logic [NUM_ISSUE-1:0]          iss_rs1_en,
   input  logic [NUM_ISSUE-1:0]          iss_rs2_en,
   input  logic [NUM_ISSUE-1:0]          iss_rd_en,
   input  logic [NUM_ISSUE*CTX_W-1:0]    iss_ctx,
   output logic [NUM_ISSUE-1:0]          iss_ready,
   output logic [NUM_ISSUE*WORD_W-1:0]   iss_rs1_data,
   output logic [NUM_ISSUE*WORD_W-1:0]   iss_rs2_data,
   input  logic [NUM_WB-1:0]             wb_valid,
   input  logic [NUM_WB*ADDR_W-1:0]      wb_rd,
   input  logic [NUM_WB*CTX_W-1:0]       wb_ctx,
   input  logic [NUM_WB*WORD_W-1:0]      wb_data,
   input  logic                          flush,
   input  logic [CTX_W-1:0]              flush_ctx,
   output logic [WORD_W-1:0]             lr_data
);

   localparam int NUM_RD = 2 * NUM_ISSUE + 1;
   localparam logic [CTX_W-1:0] CTX_ZERO = CTX_W'(CONTEXT_ZERO);

   logic [CTX_W-1:0]          pend_q [NUM_PREG];
   logic [CTX_W-1:0]          pend_d [NUM_PREG];
   logic [CTX_W-1:0]          view   [NUM_PREG];
   logic [NUM_WB-1:0]         wb_eff;
   logic [NUM_RD*ADDR_W-1:0]  rf_raddr;
   logic [NUM_RD*WORD_W-1:0]  rf_rdata;

   // Read-port map: rs1 of each slot, then rs2 of each slot, then the link register.
   always_comb begin
      rf_raddr = '0;
      for (int i = 0; i < NUM_ISSUE; i++) begin
         rf_raddr[fidx(i, ADDR_W) +: ADDR_W]             = iss_rs1[fidx(i, ADDR_W) +: ADDR_W];
         rf_raddr[fidx(NUM_ISSUE + i, ADDR_W) +: ADDR_W] = iss_rs2[fidx(i, ADDR_W) +: ADDR_W];
      end
      rf_raddr[fidx(2 * NUM_ISSUE, ADDR_W) +: ADDR_W] = ADDR_W'(LR_ADDR);
   end

   scb_regfile #(
      .NUM_PREG (NUM_PREG),
      .WORD_W   (WORD_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WB)
   ) u_regfile (
      .clk      (clk),
      .rstn     (rstn),
      .rd_addr  (rf_raddr),
      .rd_data  (rf_rdata),
      .wr_en    (wb_eff),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // Writeback filtering, hazard view, in-order issue acceptance and next pend table.
   always_comb begin : scb_comb
      logic [ADDR_W-1:0] wa;
      logic [CTX_W-1:0]  wc;
      logic [ADDR_W-1:0] a1, a2, ad;
      logic [CTX_W-1:0]  ic;
      logic              ok;
      logic              prev_ok;

      wa = '0; wc = '0; a1 = '0; a2 = '0; ad = '0; ic = '0; ok = 1'b0;
      wb_eff    = '0;
      iss_ready = '0;
      pend_d    = pend_q;
      view      = pend_q;

      // A writeback only counts if it belongs to the register's current writer and is not being squashed.
      for (int j = 0; j < NUM_WB; j++) begin
         wa = wb_rd[fidx(j, ADDR_W) +: ADDR_W];
         wc = wb_ctx[fidx(j, CTX_W) +: CTX_W];
         wb_eff[j] = wb_valid[j] && (wa != '0) && (wc != CTX_ZERO) && (pend_q[wa] == wc)
                     && !(flush && |(wc & flush_ctx));
         if (wb_eff[j]) begin
            pend_d[wa] = CTX_ZERO;
`ifdef SCB_FORWARD_EN
            view[wa] = CTX_ZERO;
`endif
         end
      end

      if (flush) begin
         for (int p = 0; p < NUM_PREG; p++) begin
            if (|(pend_q[p] & flush_ctx)) begin
               pend_d[p] = CTX_ZERO;
               view[p]   = CTX_ZERO;
            end
         end
      end

      // Slots are accepted strictly in order; each accepted claim is visible to the later slots.
      prev_ok = rstn;
      for (int i = 0; i < NUM_ISSUE; i++) begin
         a1 = iss_rs1[fidx(i, ADDR_W) +: ADDR_W];
         a2 = iss_rs2[fidx(i, ADDR_W) +: ADDR_W];
         ad = iss_rd[fidx(i, ADDR_W) +: ADDR_W];
         ic = iss_ctx[fidx(i, CTX_W) +: CTX_W];
         ok = prev_ok && iss_valid[i] && !(flush && |(ic & flush_ctx));
         if (iss_rs1_en[i] && (a1 != '0) && (view[a1] != CTX_ZERO)) ok = 1'b0;
         if (iss_rs2_en[i] && (a2 != '0) && (view[a2] != CTX_ZERO)) ok = 1'b0;
         if (iss_rd_en[i]  && (ad != '0) && (view[ad] != CTX_ZERO)) ok = 1'b0;
         iss_ready[i] = ok;
         prev_ok      = ok;
         if (ok && iss_rd_en[i] && (ad != '0)) begin
            view[ad]   = ic;
            pend_d[ad] = ic;
         end
      end

      pend_d[0] = CTX_ZERO;
   end

   // Pending-context table.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < NUM_PREG; p++) begin
            pend_q[p] <= '0;
         end
      end else begin
         pend_q <= pend_d;
      end
   end

   // Operand outputs: register-file reads, optionally overridden by same-cycle effective writebacks.
   always_comb begin
      iss_rs1_data = rf_rdata[0 +: NUM_ISSUE*WORD_W];
      iss_rs2_data = rf_rdata[NUM_ISSUE*WORD_W +: NUM_ISSUE*WORD_W];
      lr_data      = rf_rdata[2*NUM_ISSUE*WORD_W +: WORD_W];
`ifdef SCB_FORWARD_EN
      for (int i = 0; i < NUM_ISSUE; i++) begin
         for (int j = 0; j < NUM_WB; j++) begin
            if (wb_eff[j] && (wb_rd[fidx(j, ADDR_W) +: ADDR_W] == iss_rs1[fidx(i, ADDR_W) +: ADDR_W])) begin
               iss_rs1_data[fidx(i, WORD_W) +: WORD_W] = wb_data[fidx(j, WORD_W) +: WORD_W];
            end
            if (wb_eff[j] && (wb_rd[fidx(j, ADDR_W) +: ADDR_W] == iss_rs2[fidx(i, ADDR_W) +: ADDR_W])) begin
               iss_rs2_data[fidx(i, WORD_W) +: WORD_W] = wb_data[fidx(j, WORD_W) +: WORD_W];
            end
         end
      end
`endif
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: claims, RAW/WAW stalls, flush, stale writebacks, priority writes, reset.
// Latency: inputs driven after the falling edge, outputs sampled 1 time unit later.
// Backpressure: iss_ready expectations are hand-computed per vector.
module tb_reg_scoreboard;

   localparam int AW = 6;
   localparam int NI = 2;
   localparam int NW = 2;

   logic           clk = 1'b0;
   logic           rstn;
   logic [NI-1:0]  iss_valid;
   logic [NI*AW-1:0] iss_rs1, iss_rs2, iss_rd;
   logic [NI-1:0]  iss_rs1_en, iss_rs2_en, iss_rd_en;
   logic [NI*4-1:0] iss_ctx;
   logic [NI-1:0]  iss_ready;
   logic [NI*32-1:0] iss_rs1_data, iss_rs2_data;
   logic [NW-1:0]  wb_valid;
   logic [NW*AW-1:0] wb_rd;
   logic [NW*4-1:0] wb_ctx;
   logic [NW*32-1:0] wb_data;
   logic           flush;
   logic [3:0]     flush_ctx;
   logic [31:0]    lr_data;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [1:0] exp_rdy;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rstn(rstn),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
      .iss_ctx(iss_ctx), .iss_ready(iss_ready),
      .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ctx(wb_ctx), .wb_data(wb_data),
      .flush(flush), .flush_ctx(flush_ctx), .lr_data(lr_data)
   );

   task automatic clr();
      iss_valid = '0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      iss_rs1_en = '0; iss_rs2_en = '0; iss_rd_en = '0; iss_ctx = '0;
      wb_valid = '0; wb_rd = '0; wb_ctx = '0; wb_data = '0;
      flush = 1'b0; flush_ctx = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
      clr();
   endtask

   task automatic slot(input int i, input logic [5:0] rs1, input logic rs1e,
                       input logic [5:0] rs2, input logic rs2e,
                       input logic [5:0] rd, input logic rde, input logic [3:0] ctx);
      iss_valid[i] = 1'b1;
      iss_rs1[i*AW +: AW] = rs1; iss_rs1_en[i] = rs1e;
      iss_rs2[i*AW +: AW] = rs2; iss_rs2_en[i] = rs2e;
      iss_rd[i*AW +: AW]  = rd;  iss_rd_en[i]  = rde;
      iss_ctx[i*4 +: 4]   = ctx;
   endtask

   task automatic wb(input int j, input logic [5:0] rd, input logic [3:0] ctx, input logic [31:0] d);
      wb_valid[j] = 1'b1;
      wb_rd[j*AW +: AW] = rd;
      wb_ctx[j*4 +: 4]  = ctx;
      wb_data[j*32 +: 32] = d;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rstn = 1'b0; clr();
      slot(0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd2, 1'b1, 4'b0001);
      #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL reset_rs1 got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
      chk_cnt++; if (lr_data !== 32'h0) $display("FAIL reset_lr got=%h exp=0", lr_data); else pass_cnt++;
      @(negedge clk);
      rstn = 1'b1; clr();
   endtask

   task automatic test_claim_raw();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL t1_claim got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL t1_raw_stall got=%b exp=00", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); wb(0, 6'd5, 4'b0001, 32'hDEAD); #1;
`ifdef SCB_FORWARD_EN
      exp_rdy = 2'b01;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'hDEAD) $display("FAIL t1_fwd_data got=%h exp=DEAD", iss_rs1_data[31:0]); else pass_cnt++;
`else
      exp_rdy = 2'b00;
`endif
      chk_cnt++; if (iss_ready !== exp_rdy) $display("FAIL t1_wb_cycle got=%b exp=%b", iss_ready, exp_rdy); else pass_cnt++;
      cyc(); slot(0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL t1_after_wb got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'hDEAD) $display("FAIL t1_data got=%h exp=DEAD", iss_rs1_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_intra_raw();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 4'b0001);
             slot(1, 6'd0, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL t2_intra_raw got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd0, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL t2_stall got=%b exp=00", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd0, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 4'b0001); wb(1, 6'd7, 4'b0001, 32'h77); #1;
`ifdef SCB_FORWARD_EN
      exp_rdy = 2'b01;
      chk_cnt++; if (iss_rs2_data[31:0] !== 32'h77) $display("FAIL t2_fwd_data got=%h exp=77", iss_rs2_data[31:0]); else pass_cnt++;
`else
      exp_rdy = 2'b00;
`endif
      chk_cnt++; if (iss_ready !== exp_rdy) $display("FAIL t2_wb_cycle got=%b exp=%b", iss_ready, exp_rdy); else pass_cnt++;
      cyc(); slot(0, 6'd0, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL t2_accept got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs2_data[31:0] !== 32'h77) $display("FAIL t2_data got=%h exp=77", iss_rs2_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_intra_waw();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd8, 1'b1, 4'b0001);
             slot(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd8, 1'b1, 4'b0010); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL waw_intra got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd8, 4'b0001, 32'h88);
      cyc(); slot(0, 6'd8, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL waw_clear got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h88) $display("FAIL waw_data got=%h exp=88", iss_rs1_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_flush();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 1'b1, 4'b0010); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL fl_claim got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); flush = 1'b1; flush_ctx = 4'b0010;
             slot(0, 6'd9, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL fl_same_cycle got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd9, 4'b0010, 32'h1234);
             slot(0, 6'd9, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL fl_cleared got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL fl_no_fwd got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
      cyc(); slot(0, 6'd9, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL fl_dropped got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_stale_wb();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL st_claim got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd12, 4'b0010, 32'h55);
             slot(0, 6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL st_wrong_ctx got=%b exp=00", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd12, 4'b0001, 32'h56);
      cyc(); slot(0, 6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL st_ready got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h56) $display("FAIL st_data got=%h exp=56", iss_rs1_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_dual_wb();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 4'b0100);
             slot(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd1, 1'b1, 4'b0100); #1;
      chk_cnt++; if (iss_ready !== 2'b11) $display("FAIL dw_claim got=%b exp=11", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd3, 4'b0100, 32'hA); wb(1, 6'd3, 4'b0100, 32'hB);
      cyc(); wb(0, 6'd1, 4'b0100, 32'hCAFE);
             slot(0, 6'd3, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL dw_ready got=%b exp=01", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'hB) $display("FAIL dw_prio got=%h exp=B", iss_rs1_data[31:0]); else pass_cnt++;
      cyc(); #1;
      chk_cnt++; if (lr_data !== 32'hCAFE) $display("FAIL dw_lr got=%h exp=CAFE", lr_data); else pass_cnt++;
   endtask

   task automatic test_flush_block();
      cyc(); flush = 1'b1; flush_ctx = 4'b0100;
             slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1, 4'b0100);
             slot(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd11, 1'b1, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL fb_block got=%b exp=00", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd10, 1'b1, 6'd11, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL fb_no_claim got=%b exp=01", iss_ready); else pass_cnt++;
   endtask

   task automatic test_reg0();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 4'b0001);
             slot(1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b11) $display("FAIL r0_ready got=%b exp=11", iss_ready); else pass_cnt++;
      cyc(); wb(0, 6'd0, 4'b0001, 32'hFF);
             slot(0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL r0_wb_cycle got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
      cyc(); slot(0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL r0_read got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd20, 1'b1, 4'b0001);
             slot(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd21, 1'b1, 4'b0010); #1;
      chk_cnt++; if (iss_ready !== 2'b11) $display("FAIL b2b_claim got=%b exp=11", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd20, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001);
             slot(1, 6'd22, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL b2b_inorder got=%b exp=00", iss_ready); else pass_cnt++;
      cyc(); slot(0, 6'd22, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001);
             slot(1, 6'd0, 1'b0, 6'd21, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL b2b_slot1_raw got=%b exp=01", iss_ready); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      cyc(); slot(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd13, 1'b1, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b01) $display("FAIL rm_claim got=%b exp=01", iss_ready); else pass_cnt++;
      cyc(); rstn = 1'b0; slot(0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b00) $display("FAIL rm_ready_low got=%b exp=00", iss_ready); else pass_cnt++;
      chk_cnt++; if (lr_data !== 32'h0) $display("FAIL rm_lr_low got=%h exp=0", lr_data); else pass_cnt++;
      cyc(); rstn = 1'b1;
             slot(0, 6'd13, 1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 4'b0001);
             slot(1, 6'd20, 1'b1, 6'd21, 1'b1, 6'd0, 1'b0, 4'b0001); #1;
      chk_cnt++; if (iss_ready !== 2'b11) $display("FAIL rm_pend_clear got=%b exp=11", iss_ready); else pass_cnt++;
      chk_cnt++; if (iss_rs2_data[31:0] !== 32'h0) $display("FAIL rm_reg5 got=%h exp=0", iss_rs2_data[31:0]); else pass_cnt++;
      chk_cnt++; if (iss_rs1_data[31:0] !== 32'h0) $display("FAIL rm_reg13 got=%h exp=0", iss_rs1_data[31:0]); else pass_cnt++;
      chk_cnt++; if (lr_data !== 32'h0) $display("FAIL rm_lr got=%h exp=0", lr_data); else pass_cnt++;
   endtask

   initial begin
      rstn = 1'b0;
      clr();
      test_reset();
      test_claim_raw();
      test_intra_raw();
      test_intra_waw();
      test_flush();
      test_stale_wb();
      test_dual_wb();
      test_flush_block();
      test_reg0();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised successor of the single-writeback register manager. Holds the physical register file plus a per-register pending-context table. It gates multiple in-order issue slots on RAW/WAW hazards and accepts multiple writeback ports, with context-tagged write filtering. It sits between decode and the execute units and squashes pending state on branch-hazard flush by context mask.

Parameters:
NUM_PREG, 64, number of physical registers (power of 2); register 0 hardwired zero
WORD_W, 32, data width
CTX_W, 4, one-hot branch-context tag width; all-zero = "no pending writer"
NUM_ISSUE, 2, issue (read/rename) slots per cycle
NUM_WB, 2, writeback ports per cycle
LR_ADDR, 1, register exposed on the link-register read port

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
iss_valid  in  NUM_ISSUE  slot i holds an instruction
iss_rs1, iss_rs2, iss_rd  in  NUM_ISSUE*log2(NUM_PREG)  source/dest addresses, slot i at [i*AW +: AW]
iss_rs1_en, iss_rs2_en, iss_rd_en  in  NUM_ISSUE each  operand used
iss_ctx  in  NUM_ISSUE*CTX_W  context tag of slot i
iss_ready  out  NUM_ISSUE  slot i accepted this cycle
iss_rs1_data, iss_rs2_data  out  NUM_ISSUE*WORD_W  operand values
wb_valid  in  NUM_WB  writeback valid
wb_rd  in  NUM_WB*log2(NUM_PREG)  writeback address
wb_ctx  in  NUM_WB*CTX_W  tag of the writing instruction
wb_data  in  NUM_WB*WORD_W  writeback value
flush  in  1  branch hazard
flush_ctx  in  CTX_W  contexts to squash
lr_data  out  WORD_W  value of register LR_ADDR

Behaviour:
- State: regs[NUM_PREG] (WORD_W) and pend[NUM_PREG] (CTX_W). Async reset clears both. iss_ready is forced to 0 while rstn is low. Data outputs are combinational reads, so they read 0 after reset.
- Register 0: reads 0. Writes and pending updates to it are ignored.
- Writeback j is effective iff wb_valid[j], wb_rd != 0, pend[wb_rd] == wb_ctx[j] != 0, and !(flush & |(wb_ctx[j] & flush_ctx)). Non-effective writebacks (stale/flushed) are dropped silently.
- An effective writeback writes regs and clears pend at the next posedge.
- Two effective writebacks to the same rd in one cycle: the highest j wins.
- Slot hazard view: pend after this cycle's effective-writeback clears (only with SCB_FORWARD_EN), after flush clears, and after the rd claims of accepted slots k<i.
- iss_ready[i] requires all of:
  - iss_valid[i];
  - i == 0 or iss_ready[i-1] (strict in-order, no skipping);
  - !(flush & |(iss_ctx[i] & flush_ctx));
  - every enabled rs1/rs2/rd (address != 0) has a zero hazard-view entry.
- Intra-cycle WAW: a later slot whose rd equals an earlier accepted slot's rd stalls. A later slot reading the earlier slot's rd stalls (RAW).
- On accept with iss_rd_en and rd != 0: pend[rd] <= iss_ctx[i] at the posedge. This overrides a same-cycle writeback clear or flush clear of that rd.
- Flush: every pend entry with |(pend & flush_ctx) is cleared at the posedge; regs are untouched.
- All decisions are combinational in the same cycle; state updates at one posedge. No internal FSM beyond the pend table; no backpressure on writeback.

Optional Feature:
SCB_FORWARD_EN:
- Defined: effective writebacks are visible to issue in the same cycle. Their rd counts as not pending, and the iss_rs*_data mux selects the matching wb_data (highest j).
- Undefined: the consumer stalls one cycle and reads regs after the write lands. Area is smaller and timing shorter.

Decomposition:
- Shared package reg_pkg: AW = $clog2(NUM_PREG), CONTEXT_ZERO, the flat-slice index helper, and the issue/writeback field layout.
- One natural sub-module: scb_regfile, a NUM_ISSUE*2+1 read, NUM_WB write register file with register-0 masking and priority write. The scoreboard logic stays in reg_scoreboard.

Test Plan:
1. Reset then issue slot0 rd=5 ctx=0001 -> ready=1; next cycle slot0 rs1=5 -> ready=0 until wb rd=5 ctx=0001 data=0xDEAD; read returns 0xDEAD (same cycle if SCB_FORWARD_EN, else next).
2. Slot0 rd=7, slot1 rs2=7 same cycle -> ready=2'b01; slot1 accepted next cycle only after writeback to 7.
3. pend[9]=0010; flush=1 flush_ctx=0010 -> pend[9] cleared; later wb rd=9 ctx=0010 data=0x1234 dropped, regs[9] unchanged.
4. Two wb to rd=3, ctx matching, data 0xA (j=0) and 0xB (j=1) -> regs[3]=0xB.
5. Slot0 ctx=0100 with flush_ctx=0100, slot1 hazard-free -> ready=2'b00 (in-order block).
6. Assert rstn low mid-stream with pending entries -> iss_ready=0 immediately; after release all pend=0, all reads 0, lr_data=0.
